pfpred_serializer: RTL
======================

Name: pfpred_serializer

Overview:
- Consumer of the prefetch monitor's prediction packet. It sits between the monitor and the core's prefetch request logic.
- Buffers up to DEPTH 4-delta prediction packets.
- Drops deltas with a zero value or a low weight.
- Issues the remaining deltas one per cycle as single prefetch requests, using the codebase's valid/retry handshake on both sides.

Parameters:
- DEPTH, 4, number of packet entries in the input FIFO; must be a power of 2 and at least 2.
- WMIN, 1, minimum weight (PF_weigth_type, unsigned) for a delta to be issued.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- pfmtocore_pred_valid  input  1  prediction packet valid
- pfmtocore_pred_retry  output  1  back-pressure to the monitor
- pfmtocore_pred  input  PF_pred_type  packed {pcsign, d0_rid, d0_val, d0_w, d1_rid, d1_val, d1_w, d2_rid, d2_val, d2_w, d3_rid, d3_val, d3_w}
- pfreq_valid  output  1  prefetch request valid
- pfreq_retry  input  1  back-pressure from the consumer
- pfreq_pcsign  output  SC_pcsign_type  pcsign of the source packet
- pfreq_rid  output  SC_robid_type  rid of the issued slot
- pfreq_delta  output  PF_delta_type  delta value
- pfreq_w  output  PF_weigth_type  weight
- pfreq_last  output  1  last qualifying slot of this packet

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - FIFO empty, slot index 0.
  - pfreq_valid=0; pfreq_last=0; all pfreq data outputs 0.
  - pfmtocore_pred_retry=1 while reset is high, 0 on the first cycle after reset.
  - Reset mid-packet discards all buffered and partially issued packets.
- Transfer rule on both interfaces: a transfer occurs when valid=1 and retry=0 in the same cycle.
- Input side:
  - pfmtocore_pred_retry = FIFO full, from registered state only.
  - No push-through when full, even if a pop occurs in the same cycle.
  - Push is written at the clock edge.
- Slot qualification: slot i qualifies iff d_i_val != 0 and d_i_w >= WMIN.
  - The qualifying mask is computed from the head entry.
- States:
  - IDLE: FIFO empty, pfreq_valid=0. Goes to ISSUE when the FIFO becomes non-empty.
  - ISSUE: present the lowest qualifying slot index >= cur_slot.
- Output in ISSUE:
  - pfreq_valid=1; outputs come from FIFO head registers plus the slot mux.
  - Outputs are held stable while pfreq_retry=1.
  - When the transfer occurs, cur_slot advances to the next qualifying slot.
  - pfreq_last=1 when no higher qualifying slot exists. Its transfer pops the head and resets cur_slot to 0.
- Empty mask: if the head has no qualifying slots, pfreq_valid=0 for one cycle and the head pops (bubble). No request is issued.
- Latency: a packet accepted at cycle N gives its first request at N+1 at the earliest.
- Throughput: 1 request per cycle sustained, including back-to-back packets. The next packet's first slot follows the previous packet's last slot with no bubble.
- Simultaneous push and pop in one cycle (FIFO not full) is legal; occupancy is unchanged.
- Pointers are log2(DEPTH) bits wrapping modulo DEPTH, plus one extra bit for full/empty.
- Assertions: pfreq data stable while valid && retry; no push when full.

Optional Feature:
- Macro: PFPRED_STATS_EN.
- When defined, adds two outputs:
  - pfpred_issue_cnt: 16-bit, increments on each pfreq transfer.
  - pfpred_drop_cnt: 16-bit, increments by the number of non-qualifying slots at each head pop.
- Both counters saturate at 0xFFFF and reset to 0.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (next to SC_pcsign_type, SC_robid_type, PF_delta_type, PF_weigth_type):
  - PF_pred_type packed struct.
  - PF_predslot_type {rid, val, w}.
  - PF_NSLOTS=4.
- Sub-module pfpred_fifo: generic DEPTH-entry packet FIFO with full/empty flags.
- Slot selection and the FSM stay in the top module.

Test Plan:
- One packet, all 4 slots with w=3 and deltas 1,2,3,4, pfreq_retry=0 → requests on cycles N+1..N+4 with deltas 1,2,3,4; pfreq_last=1 only on delta 4.
- Slot 1 w=0 and slot 2 val=0 (WMIN=1) → only slots 0 and 3 issued on consecutive cycles; last=1 on slot 3; with the macro, drop_cnt=2.
- All slots val=0 → pfreq_valid stays 0, entry popped after one cycle, next packet issues normally.
- pfreq_retry held for 3 cycles while slot 1 is presented → rid/delta/w/last unchanged for those cycles; slot 1 is issued exactly once, then slot 2.
- DEPTH=4, pfreq_retry=1, 5 packets offered back-to-back → pfmtocore_pred_retry=1 after the 4th accept. Releasing pfreq_retry drains the packets in order, and the 5th is accepted on the cycle after the first pop.
- Reset asserted after 2 of 4 slots have issued → next cycle pfreq_valid=0, FIFO empty; the remaining slots are never issued.

Source files
------------

// File: rtl/pfpred_pkg.sv
// Shared types for the prefetch prediction path: packet layout, slot view,
// and small helpers used by the serializer.
package pfpred_pkg;

  localparam int PF_NSLOTS = 4;

  typedef logic [11:0] SC_pcsign_type;
  typedef logic [5:0]  SC_robid_type;
  typedef logic [7:0]  PF_delta_type;
  typedef logic [2:0]  PF_weigth_type;

  typedef struct packed {
    SC_robid_type  rid;
    PF_delta_type  val;
    PF_weigth_type w;
  } PF_predslot_type;

  // Field order matches the monitor's flat {pcsign, d0.., d1.., d2.., d3..} packing.
  typedef struct packed {
    SC_pcsign_type   pcsign;
    PF_predslot_type d0;
    PF_predslot_type d1;
    PF_predslot_type d2;
    PF_predslot_type d3;
  } PF_pred_type;

  typedef enum logic {ST_IDLE, ST_ISSUE} pf_state_e;

  function automatic PF_predslot_type pf_slot(input PF_pred_type p, input logic [1:0] idx);
    case (idx)
      2'd0:    return p.d0;
      2'd1:    return p.d1;
      2'd2:    return p.d2;
      default: return p.d3;
    endcase
  endfunction

  function automatic logic pf_qual(input PF_predslot_type s, input PF_weigth_type wmin);
    return (s.val != '0) && (s.w >= wmin);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/pfpred_serializer_fifo.sv
// Generic DEPTH-entry FIFO with extra-bit pointers for full/empty; the head
// entry is read combinationally from the storage registers.
module pfpred_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_wr;
  logic         w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count = r_wptr - r_rptr;
  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: consumers only look at it while non-empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(i_push && o_full));

endmodule

// File: rtl/pfpred_serializer.sv
// Serializes buffered 4-delta prediction packets into single prefetch requests,
// skipping zero/low-weight deltas. PFPRED_STATS_EN adds issue/drop counters.
module pfpred_serializer
  import pfpred_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WMIN  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pfmtocore_pred_valid,
  output logic          pfmtocore_pred_retry,
  input  PF_pred_type   pfmtocore_pred,
  output logic          pfreq_valid,
  input  logic          pfreq_retry,
  output SC_pcsign_type pfreq_pcsign,
  output SC_robid_type  pfreq_rid,
  output PF_delta_type  pfreq_delta,
  output PF_weigth_type pfreq_w,
  output logic          pfreq_last
`ifdef PFPRED_STATS_EN
  ,
  output logic [15:0]   pfpred_issue_cnt,
  output logic [15:0]   pfpred_drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PF_NSLOTS-1:0] ALL_SLOTS = '1;

  logic                 w_full, w_empty, w_push, w_pop, w_xfer, w_bubble, w_last;
  logic [AW:0]          w_count;
  PF_pred_type          w_head;
  logic [PF_NSLOTS-1:0] w_mask, w_cand;
  logic [1:0]           w_sel;
  PF_predslot_type      w_slot;
  pf_state_e            r_state;
  logic [1:0]           r_slot;

  pfpred_fifo #(.DEPTH(DEPTH), .W($bits(PF_pred_type))) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (pfmtocore_pred),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign pfmtocore_pred_retry = reset | w_full;
  assign w_push = pfmtocore_pred_valid & ~pfmtocore_pred_retry;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PF_NSLOTS; i++)
      w_mask[i] = pf_qual(pf_slot(w_head, 2'(i)), PF_weigth_type'(WMIN));
  end

  assign w_cand = w_mask & (ALL_SLOTS << r_slot);

  always_comb begin
    w_sel = '0;
    for (int i = PF_NSLOTS-1; i >= 0; i--)
      if (w_cand[i]) w_sel = 2'(i);
  end

  assign w_last   = (w_cand >> (3'(w_sel) + 3'd1)) == '0;
  assign w_slot   = pf_slot(w_head, w_sel);
  assign w_bubble = (r_state == ST_ISSUE) && !w_empty && (w_mask == '0);
  assign pfreq_valid = (r_state == ST_ISSUE) && !w_empty && (w_cand != '0);
  assign w_xfer   = pfreq_valid & ~pfreq_retry;
  assign w_pop    = w_bubble | (w_xfer & w_last);

  // Data is forced to zero whenever no request is presented.
  assign pfreq_pcsign = pfreq_valid ? w_head.pcsign : '0;
  assign pfreq_rid    = pfreq_valid ? w_slot.rid    : '0;
  assign pfreq_delta  = pfreq_valid ? w_slot.val    : '0;
  assign pfreq_w      = pfreq_valid ? w_slot.w      : '0;
  assign pfreq_last   = pfreq_valid & w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_push) r_state <= ST_ISSUE;
        ST_ISSUE: begin
          if (w_pop) begin
            r_slot <= '0;
            if (!w_push && w_count == (AW+1)'(1)) r_state <= ST_IDLE;
          end else if (w_xfer) begin
            r_slot <= w_sel + 2'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PFPRED_STATS_EN
  logic [2:0] w_ndrop;
  assign w_ndrop = 3'(PF_NSLOTS - $countones(w_mask));

  always_ff @(posedge clk) begin
    if (reset) begin
      pfpred_issue_cnt <= '0;
      pfpred_drop_cnt  <= '0;
    end else begin
      if (w_xfer) pfpred_issue_cnt <= sat_add16(pfpred_issue_cnt, 16'd1);
      if (w_pop)  pfpred_drop_cnt  <= sat_add16(pfpred_drop_cnt, 16'(w_ndrop));
    end
  end
`endif

  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (pfreq_valid && pfreq_retry) |=> (pfreq_valid &&
      $stable({pfreq_pcsign, pfreq_rid, pfreq_delta, pfreq_w, pfreq_last})));

endmodule
